float_round_arb: RTL and testbench

FLOAT_ROUND_ARB -- requirements
Module: float_round_arb

---
 rtl/float_pkg.sv | 12 +
 rtl/float_rounder.sv | 38 +++
 rtl/float_round_arb.sv | 145 ++++++++++++++
 tb/tb_float_round_arb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared floating-point types: rounding-mode encodings used by the rounder and its wrappers.
package float_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } round_mode_t;

endpackage

// File: rtl/float_rounder.sv
// Combinational mantissa rounder: applies the rounding mode to {round, sticky} and adds the
// increment with carry-out. Unknown modes fall back to round-toward-zero and are flagged.
module float_rounder
  import float_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         sign_i,
  input  logic [N-1:0] mant_i,
  input  logic [1:0]   rs_i,
  input  logic [2:0]   rm_i,
  output logic [N:0]   result_o,
  output logic         inexact_o,
  output logic         illegal_rm_o
);

  logic rnd, stk, inc;

  assign rnd = rs_i[1];
  assign stk = rs_i[0];

  always_comb begin
    inc          = 1'b0;
    illegal_rm_o = 1'b0;
    case (rm_i)
      RNE:     inc = rnd & (stk | mant_i[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = (rnd | stk) & sign_i;
      RUP:     inc = (rnd | stk) & ~sign_i;
      RMM:     inc = rnd;
      default: illegal_rm_o = 1'b1;
    endcase
  end

  assign result_o  = {1'b0, mant_i} + {{N{1'b0}}, inc};
  assign inexact_o = rnd | stk;

endmodule

// File: rtl/float_round_arb.sv
// Arbitrated rounding stage: picks one requester per load, rounds its mantissa and holds the
// result in a single output register. Define FLOAT_ROUND_ARB_RR_EN for round-robin arbitration.
module float_round_arb
  import float_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_sign,
  input  logic [NUM_REQ*N-1:0]   req_mant,
  input  logic [NUM_REQ*2-1:0]   req_sticky,
  input  logic [NUM_REQ*3-1:0]   req_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IdW-1:0]         out_id,
  output logic [N:0]             out_result,
  output logic                   out_inexact,
  output logic                   out_illegal_rm
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic [IdW-1:0] gnt_idx;
  logic           gnt_found;
  logic           load;

  logic           g_sign;
  logic [N-1:0]   g_mant;
  logic [1:0]     g_rs;
  logic [2:0]     g_rm;
  logic [N:0]     rnd_result;
  logic           rnd_inexact, rnd_illegal;

  logic [IdW-1:0] id_q;
  logic [N:0]     result_q;
  logic           inexact_q, illegal_q;

`ifdef FLOAT_ROUND_ARB_RR_EN
  logic [IdW-1:0] ptr_q;
  int unsigned    cand;

  // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdW'(k);
      end
    end
  end
`endif

  // rst_n gates load so no handshake can occur while reset is held.
  assign load = rst_n & ((state_q == StEmpty) | out_ready) & gnt_found;

  assign g_sign = req_sign[gnt_idx];
  assign g_mant = req_mant[32'(gnt_idx) * N +: N];
  assign g_rs   = req_sticky[32'(gnt_idx) * 2 +: 2];
  assign g_rm   = req_rm[32'(gnt_idx) * 3 +: 3];

  float_rounder #(
    .N (N)
  ) u_rounder (
    .sign_i       (g_sign),
    .mant_i       (g_mant),
    .rs_i         (g_rs),
    .rm_i         (g_rm),
    .result_o     (rnd_result),
    .inexact_o    (rnd_inexact),
    .illegal_rm_o (rnd_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (out_ready && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (load) req_ready = NUM_REQ'(1) << gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      result_q  <= '0;
      inexact_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load) begin
      id_q      <= gnt_idx;
      result_q  <= rnd_result;
      inexact_q <= rnd_inexact;
      illegal_q <= rnd_illegal;
    end
  end

  assign out_valid      = (state_q == StFull);
  assign out_id         = id_q;
  assign out_result     = result_q;
  assign out_inexact    = inexact_q;
  assign out_illegal_rm = illegal_q;

endmodule

// File: tb/tb_float_round_arb.sv
// Directed bench for float_round_arb (N=8, two requesters) with hand-computed expectations.
module tb_float_round_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_sign;
  logic [15:0] req_mant;
  logic [3:0]  req_sticky;
  logic [5:0]  req_rm;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_id;
  logic [8:0]  out_result;
  logic        out_inexact;
  logic        out_illegal_rm;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  float_round_arb #(
    .N       (8),
    .NUM_REQ (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_sign       (req_sign),
    .req_mant       (req_mant),
    .req_sticky     (req_sticky),
    .req_rm         (req_rm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_id         (out_id),
    .out_result     (out_result),
    .out_inexact    (out_inexact),
    .out_illegal_rm (out_illegal_rm)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic sgn, input logic [7:0] a,
                         input logic [1:0] st, input logic [2:0] rm);
    req_valid[i]        = v;
    req_sign[i]         = sgn;
    req_mant[i*8 +: 8]  = a;
    req_sticky[i*2 +: 2] = st;
    req_rm[i*3 +: 3]    = rm;
  endtask

  // One single-requester transaction with out_ready held high.
  task automatic one(input string tag, input int i, input logic sgn, input logic [7:0] a,
                     input logic [1:0] st, input logic [2:0] rm, input logic [8:0] exp_res,
                     input logic exp_inex, input logic exp_ill);
    logic [1:0] exp_rdy;
    exp_rdy   = 2'b01 << i;
    out_ready = 1'b1;
    set_req(i, 1'b1, sgn, a, st, rm);
    #1;
    chk({tag, ".ready"}, 16'(req_ready), 16'(exp_rdy));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk({tag, ".valid"}, 16'(out_valid), 16'd1);
    chk({tag, ".result"}, 16'(out_result), 16'(exp_res));
    chk({tag, ".id"}, 16'(out_id), 16'(i));
    chk({tag, ".inexact"}, 16'(out_inexact), 16'(exp_inex));
    chk({tag, ".illegal"}, 16'(out_illegal_rm), 16'(exp_ill));
  endtask

  logic [3:0] rr_ids;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_sign   = 2'b00;
    req_mant   = '0;
    req_sticky = '0;
    req_rm     = '0;
    out_ready  = 1'b0;
`ifdef FLOAT_ROUND_ARB_RR_EN
    rr_ids = 4'b1010;
`else
    rr_ids = 4'b0000;
`endif

    // Reset state, including req_ready held low with requests pending.
    #1;
    req_valid = 2'b11;
    #1;
    chk("rst.ready", 16'(req_ready), 16'd0);
    chk("rst.valid", 16'(out_valid), 16'd0);
    chk("rst.result", 16'(out_result), 16'd0);
    chk("rst.id", 16'(out_id), 16'd0);
    chk("rst.flags", 16'({out_inexact, out_illegal_rm}), 16'd0);
    @(posedge clk);
    #1;
    chk("rst.hold", 16'(out_valid), 16'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle.valid", 16'(out_valid), 16'd0);

    one("rne_tie_odd", 0, 1'b0, 8'h05, 2'b10, 3'b000, 9'h006, 1'b1, 1'b0);
    one("rne_tie_even", 0, 1'b0, 8'h04, 2'b10, 3'b000, 9'h004, 1'b1, 1'b0);
    one("rne_carry", 1, 1'b0, 8'hFF, 2'b11, 3'b000, 9'h100, 1'b1, 1'b0);
    one("rdn_neg", 1, 1'b1, 8'h10, 2'b01, 3'b010, 9'h011, 1'b1, 1'b0);
    one("rdn_pos", 1, 1'b0, 8'h10, 2'b01, 3'b010, 9'h010, 1'b1, 1'b0);
    one("rup_pos", 0, 1'b0, 8'h10, 2'b01, 3'b011, 9'h011, 1'b1, 1'b0);
    one("rmm", 0, 1'b0, 8'h03, 2'b10, 3'b100, 9'h004, 1'b1, 1'b0);
    one("rtz", 1, 1'b1, 8'h03, 2'b11, 3'b001, 9'h003, 1'b1, 1'b0);
    one("exact", 0, 1'b0, 8'h2A, 2'b00, 3'b000, 9'h02A, 1'b0, 1'b0);
    one("illegal", 0, 1'b0, 8'h07, 2'b11, 3'b101, 9'h007, 1'b1, 1'b1);

    // Backpressure: result held for three cycles, waiting requester not granted.
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 1'b0, 8'h41, 2'b00, 3'b001);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    set_req(1, 1'b1, 1'b0, 8'h50, 2'b00, 3'b001);
    out_ready = 1'b0;
    #1;
    chk("bp.ready0", 16'(req_ready), 16'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp.ready", 16'(req_ready), 16'd0);
      chk("bp.valid", 16'(out_valid), 16'd1);
      chk("bp.result", 16'(out_result), 16'h041);
      chk("bp.id", 16'(out_id), 16'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 16'(req_ready), 16'b10);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("bp.next_result", 16'(out_result), 16'h050);
    chk("bp.next_id", 16'(out_id), 16'd1);
    chk("bp.next_valid", 16'(out_valid), 16'd1);
    @(posedge clk);
    #1;
    chk("bp.drain", 16'(out_valid), 16'd0);

    // Reset while FULL clears the output without a clock edge.
    set_req(0, 1'b1, 1'b0, 8'h77, 2'b11, 3'b000);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.full", 16'(out_valid), 16'd1);
    set_req(0, 1'b1, 1'b0, 8'h20, 2'b00, 3'b001);
    set_req(1, 1'b1, 1'b0, 8'h30, 2'b00, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 16'(out_valid), 16'd0);
    chk("mid.result", 16'(out_result), 16'd0);
    chk("mid.ready", 16'(req_ready), 16'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Both requesters valid for four cycles.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("arb.id", 16'(out_id), 16'(rr_ids[c]));
      chk("arb.result", 16'(out_result), rr_ids[c] ? 16'h030 : 16'h020);
      chk("arb.valid", 16'(out_valid), 16'd1);
    end
    req_valid = 2'b00;
    @(posedge clk);
    #1;
    chk("arb.drain", 16'(out_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
